// File: rtl/xfer_addr_sequencer_pkg.sv
// Shared definitions for the transfer address sequencer: default widths and
// the 2-bit state encoding shared by the RTL, the bus interface and the bench.
package xfer_addr_sequencer_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 8;
    localparam int PATH_DELAY_DEF = 3;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/xfer_addr_sequencer_if.sv
// Bus between the transfer controller and its requester / memory model.
interface xfer_addr_sequencer_if
    import xfer_addr_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) ();

    // Handshake: start is a one-cycle request seen only in IDLE. rd_en/wr_en
    // stay high, with addresses stable, until mem_ready is high in the same
    // cycle; that cycle completes the access. done pulses once per transfer.
    logic                  start;
    logic [ADDR_WIDTH-1:0] src_base;
    logic [ADDR_WIDTH-1:0] dst_base;
    logic [CNT_WIDTH-1:0]  len;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic                  rd_en;
    logic                  wr_en;
    logic                  busy;
    logic                  done;
    logic                  err;
    state_t                dbg_state;

    modport master (
        output start, src_base, dst_base, len, mem_ready,
        input  src_addr, dst_addr, rd_en, wr_en, busy, done, err, dbg_state
    );

    modport slave (
        input  start, src_base, dst_base, len, mem_ready,
        output src_addr, dst_addr, rd_en, wr_en, busy, done, err, dbg_state
    );

endinterface

// File: rtl/NBitFullAdder.sv
// N-bit ripple-carry adder used by the transfer path for address and count updates.
module NBitFullAdder #(
    parameter int N          = 8,
    parameter int PATH_DELAY = 0
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Delay only shapes behavioural models of this adder; the gate form ignores it.
    localparam int PATH_DELAY_UNUSED = PATH_DELAY;

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/xfer_addr_sequencer.sv
// Memory-to-memory transfer controller: walks source/destination addresses one
// word at a time, strobing read then write, and stops early on address overflow.
module xfer_addr_sequencer
    import xfer_addr_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int PATH_DELAY = PATH_DELAY_DEF
) (
    input logic                  clk,
    input logic                  rst,
    xfer_addr_sequencer_if.slave bus
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [CNT_WIDTH-1:0]  rem_q;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] src_sum;
    logic [ADDR_WIDTH-1:0] dst_sum;
    logic [CNT_WIDTH-1:0]  rem_sum;
    logic                  src_cout;
    logic                  dst_cout;
    logic                  rem_cout_unused;

    NBitFullAdder #(.N(ADDR_WIDTH), .PATH_DELAY(PATH_DELAY)) u_src_add (
        .a    (src_q),
        .b    (ADDR_WIDTH'(1)),
        .cin  (1'b0),
        .sum  (src_sum),
        .cout (src_cout)
    );

    NBitFullAdder #(.N(ADDR_WIDTH), .PATH_DELAY(PATH_DELAY)) u_dst_add (
        .a    (dst_q),
        .b    (ADDR_WIDTH'(1)),
        .cin  (1'b0),
        .sum  (dst_sum),
        .cout (dst_cout)
    );

    // Adding all-ones decrements the remaining count.
    NBitFullAdder #(.N(CNT_WIDTH), .PATH_DELAY(PATH_DELAY)) u_cnt_add (
        .a    (rem_q),
        .b    ({CNT_WIDTH{1'b1}}),
        .cin  (1'b0),
        .sum  (rem_sum),
        .cout (rem_cout_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            src_q <= '0;
            dst_q <= '0;
            rem_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        src_q <= bus.src_base;
                        dst_q <= bus.dst_base;
                        rem_q <= bus.len;
                        err_q <= 1'b0;
                        state <= (bus.len == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (bus.mem_ready) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (bus.mem_ready) begin
                        rem_q <= rem_sum;
                        // The last word may wrap harmlessly; any earlier wrap aborts
                        // with the addresses frozen at the last good word.
                        if (rem_q == CNT_WIDTH'(1)) begin
                            src_q <= src_sum;
                            dst_q <= dst_sum;
                            state <= ST_DONE;
                        end else if (src_cout || dst_cout) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            src_q <= src_sum;
                            dst_q <= dst_sum;
                            state <= ST_READ;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.src_addr  = src_q;
    assign bus.dst_addr  = dst_q;
    assign bus.rd_en     = (state == ST_READ);
    assign bus.wr_en     = (state == ST_WRITE);
    assign bus.busy      = (state == ST_READ) || (state == ST_WRITE);
    assign bus.done      = (state == ST_DONE);
    assign bus.err       = err_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_xfer_addr_sequencer.sv
// Directed bench for xfer_addr_sequencer: expected strobe/done events are queued
// as each transfer is launched and matched by a monitor on every active cycle.
module tb_xfer_addr_sequencer;
    import xfer_addr_sequencer_pkg::*;

    // Event record: {busy, err, kind[1:0], cycle[7:0], src[7:0], dst[7:0]}
    localparam int W = 28;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_WR   = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xfer_addr_sequencer_if bus ();

    xfer_addr_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;
    logic [W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard helpers ----------------
    function automatic logic [W-1:0] ev(logic [1:0] kind, int c, logic [7:0] s,
                                        logic [7:0] d, logic e);
        logic b;
        b = (kind == K_RD) || (kind == K_WR);
        return {b, e, kind, 8'(c), s, d};
    endfunction

    task automatic exp_ev(logic [1:0] kind, int c, logic [7:0] s, logic [7:0] d, logic e);
        exp_q.push_back(ev(kind, c, s, d, e));
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] act_rec;
    logic [W-1:0] exp_rec;
    logic [1:0]   act_kind;

    always @(negedge clk) begin
        if (bus.rd_en || bus.wr_en || bus.done) begin
            act_kind = bus.done ? K_DONE : (bus.wr_en ? K_WR : K_RD);
            act_rec  = {bus.busy, bus.err, act_kind, 8'(cyc - t0), bus.src_addr, bus.dst_addr};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got busy=%0b err=%0b kind=%0d cyc=%0d src=%h dst=%h, required no event",
                         act_rec[27], act_rec[26], act_rec[25:24], act_rec[23:16], act_rec[15:8], act_rec[7:0]);
            end else begin
                exp_rec = exp_q.pop_front();
                if (act_rec !== exp_rec) begin
                    errors++;
                    $display("FAIL event: got busy=%0b err=%0b kind=%0d cyc=%0d src=%h dst=%h, required busy=%0b err=%0b kind=%0d cyc=%0d src=%h dst=%h",
                             act_rec[27], act_rec[26], act_rec[25:24], act_rec[23:16], act_rec[15:8], act_rec[7:0],
                             exp_rec[27], exp_rec[26], exp_rec[25:24], exp_rec[23:16], exp_rec[15:8], exp_rec[7:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic start_xfer(logic [7:0] s, logic [7:0] d, logic [7:0] l);
        bus.start    = 1'b1;
        bus.src_base = s;
        bus.dst_base = d;
        bus.len      = l;
        t0           = cyc;
        step();
        bus.start    = 1'b0;
    endtask

    // Let the transfer finish, then require that every queued event was seen.
    task automatic drain(string name, int n);
        repeat (n) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: got %0d pending events, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(string name);
        check({name, "_strobes"}, {27'd0, bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.err}, 32'd0);
        check({name, "_src"}, {24'd0, bus.src_addr}, 32'd0);
        check({name, "_dst"}, {24'd0, bus.dst_addr}, 32'd0);
        check({name, "_state"}, {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.src_base  = '0;
        bus.dst_base  = '0;
        bus.len       = '0;
        bus.mem_ready = 1'b1;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Basic transfer: 3 words, no backpressure
        exp_ev(K_RD,   1, 8'h10, 8'h80, 1'b0);
        exp_ev(K_WR,   2, 8'h10, 8'h80, 1'b0);
        exp_ev(K_RD,   3, 8'h11, 8'h81, 1'b0);
        exp_ev(K_WR,   4, 8'h11, 8'h81, 1'b0);
        exp_ev(K_RD,   5, 8'h12, 8'h82, 1'b0);
        exp_ev(K_WR,   6, 8'h12, 8'h82, 1'b0);
        exp_ev(K_DONE, 7, 8'h13, 8'h83, 1'b0);
        start_xfer(8'h10, 8'h80, 8'd3);
        drain("basic", 8);

        // Zero length: done right away, addresses at the bases
        exp_ev(K_DONE, 1, 8'h33, 8'h44, 1'b0);
        start_xfer(8'h33, 8'h44, 8'd0);
        drain("zero_len", 3);

        // Backpressure: mem_ready low for two cycles in the first WRITE
        exp_ev(K_RD,   1, 8'h10, 8'h80, 1'b0);
        exp_ev(K_WR,   2, 8'h10, 8'h80, 1'b0);
        exp_ev(K_WR,   3, 8'h10, 8'h80, 1'b0);
        exp_ev(K_WR,   4, 8'h10, 8'h80, 1'b0);
        exp_ev(K_RD,   5, 8'h11, 8'h81, 1'b0);
        exp_ev(K_WR,   6, 8'h11, 8'h81, 1'b0);
        exp_ev(K_DONE, 7, 8'h12, 8'h82, 1'b0);
        start_xfer(8'h10, 8'h80, 8'd2);
        step();
        bus.mem_ready = 1'b0;
        step();
        step();
        bus.mem_ready = 1'b1;
        drain("backpressure", 6);

        // Mid-transfer overflow: second increment of src wraps and aborts
        exp_ev(K_RD,   1, 8'hFE, 8'h20, 1'b0);
        exp_ev(K_WR,   2, 8'hFE, 8'h20, 1'b0);
        exp_ev(K_RD,   3, 8'hFF, 8'h21, 1'b0);
        exp_ev(K_WR,   4, 8'hFF, 8'h21, 1'b0);
        exp_ev(K_DONE, 5, 8'hFF, 8'h21, 1'b1);
        start_xfer(8'hFE, 8'h20, 8'd4);
        repeat (5) step();
        check("overflow_err_held", {31'd0, bus.err}, 32'd1);
        check("overflow_idle", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
        drain("overflow", 2);

        // Final-word wrap is not an error, and the new start clears err
        exp_ev(K_RD,   1, 8'hFF, 8'h50, 1'b0);
        exp_ev(K_WR,   2, 8'hFF, 8'h50, 1'b0);
        exp_ev(K_DONE, 3, 8'h00, 8'h51, 1'b0);
        start_xfer(8'hFF, 8'h50, 8'd1);
        drain("final_wrap", 4);

        // Ignored start in READ, then reset mid-transfer with no done
        exp_ev(K_RD,   1, 8'h40, 8'h60, 1'b0);
        exp_ev(K_WR,   2, 8'h40, 8'h60, 1'b0);
        exp_ev(K_RD,   3, 8'h41, 8'h61, 1'b0);
        start_xfer(8'h40, 8'h60, 8'd5);
        bus.start    = 1'b1;
        bus.src_base = 8'h99;
        bus.dst_base = 8'h77;
        bus.len      = 8'd0;
        step();
        bus.start    = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        drain("mid_reset", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xfer_addr_sequencer.md
# xfer_addr_sequencer

Control stage that drives the ripple-carry adders in the memory-to-memory transfer path. It generates one source/destination address pair per word, feeds the current addresses and the remaining word count into N-bit adder instances, registers their results, and sequences read/write strobes toward the memory model under a ready handshake. A transfer is launched by a one-cycle `start` and ends with a one-cycle `done`, plus `err` if an address overflows.

## Interface
- `ADDR_WIDTH`, 8: width of the source and destination addresses.
- `CNT_WIDTH`, 8: width of the transfer length and the remaining-word counter.
- `PATH_DELAY`, 3: delay passed to each adder instance. Simulation only; it must settle well inside one clock period.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: launches a transfer. Sampled only in IDLE.
- `src_base` input ADDR_WIDTH: first source address, captured on an accepted `start`.
- `dst_base` input ADDR_WIDTH: first destination address, captured on an accepted `start`.
- `len` input CNT_WIDTH: word count, captured on an accepted `start`. 0 is legal.
- `mem_ready` input 1: memory has completed the current read or write this cycle.
- `src_addr` output ADDR_WIDTH: registered current source address.
- `dst_addr` output ADDR_WIDTH: registered current destination address.
- `rd_en` output 1: high exactly while in READ.
- `wr_en` output 1: high exactly while in WRITE.
- `busy` output 1: high in READ or WRITE.
- `done` output 1: one-cycle pulse in DONE.
- `err` output 1: registered. Set on an aborting overflow; cleared by the next accepted `start` or by `rst`.

## Operation
- States are IDLE, READ, WRITE and DONE. `rd_en`, `wr_en`, `busy` and `done` decode directly from the registered state, so no output depends combinationally on an input.
- IDLE:
  - `start=1` captures `src_base`, `dst_base` and `len`, and clears `err`.
  - If `len==0`, go to DONE; otherwise go to READ.
  - `start` outside IDLE is ignored.
- READ: hold until `mem_ready=1`, then go to WRITE.
- WRITE: hold until `mem_ready=1`. In that cycle:
  - Load `src_addr` and `dst_addr` with their adder sums (address + 1).
  - Load `remaining` with its adder sum (`remaining` + all-ones, i.e. minus 1).
  - Next state:
    - If `remaining==1`, go to DONE. Overflow on this final increment is ignored and the addresses still load.
    - Otherwise, if either address adder `cout==1`, set `err`, leave the addresses unchanged, and go to DONE.
    - Otherwise go to READ.
- DONE: lasts one cycle, then IDLE.
- Arithmetic uses three adder instances:
  - Source adder: a=`src_addr`, b=1.
  - Destination adder: a=`dst_addr`, b=1.
  - Count adder: a=`remaining`, b={CNT_WIDTH{1'b1}}. Its `cout` is unused.
- Addresses never wrap silently mid-transfer.

## Timing
- Reset values: state IDLE; `src_addr`, `dst_addr` and `remaining` 0; `rd_en`, `wr_en`, `busy`, `done` and `err` 0.
- `rst` is honoured in any state, including mid-transfer. Following cycle: outputs at reset values, and no `done` pulse.
- Label the cycle in which `start` is sampled as cycle 0. With `mem_ready` tied 1:
  - READ in cycles 1,3,…,2·len−1; WRITE in cycles 2,4,…,2·len.
  - `done` in cycle 2·len+1; IDLE in cycle 2·len+2.
  - A new `start` is accepted no earlier than cycle 2·len+2.
- Each low `mem_ready` cycle extends the current READ or WRITE by exactly one cycle.
- `len==0`: `done` in cycle 1, with no `rd_en` and no `wr_en`.
- `src_addr` and `dst_addr` are stable for the whole of each READ/WRITE pair.

## Structure
- Shared package holds the state encoding (2-bit: IDLE=0, READ=1, WRITE=2, DONE=3) and the default widths.
- Sub-module: the existing ripple adder `NBitFullAdder`, instanced three times (two at ADDR_WIDTH, one at CNT_WIDTH). No other sub-modules.

## Test plan
- Basic transfer: `src_base`=0x10, `dst_base`=0x80, `len`=3, `mem_ready`=1.
  - Reads at 0x10/0x11/0x12 in cycles 1/3/5; writes at 0x80/0x81/0x82 in cycles 2/4/6.
  - `done` in cycle 7; `err`=0.
- Zero length: `len`=0 → `done` in cycle 1, no strobes, addresses equal the bases.
- Backpressure: `len`=2 with `mem_ready` low for 2 cycles in the first WRITE → `wr_en` held 3 cycles at 0x80, `done` in cycle 7.
- Mid-transfer overflow: `src_base`=0xFE, `len`=4.
  - Words at 0xFE and 0xFF complete.
  - The second WRITE sets `err`=1; `done` in cycle 5; `src_addr` stays 0xFF.
- Final-word wrap: `src_base`=0xFF, `len`=1 → single read/write pair, `done` in cycle 3, `err`=0.
- Reset and ignored start:
  - `rst` pulse in cycle 3 of a `len`=5 transfer → IDLE with all outputs 0 the next cycle, and no `done`.
  - `start` pulsed while in READ is ignored.
